load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter XLEN, 32, datapath width.
REQ-002 SHALL have parameter TIMEOUT, 255, max cycles waiting for bus_ack; 8-bit counter; legal range 1..255.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port valid  input  1  pipeline presents an instruction this cycle.
REQ-006 SHALL have port operation  input  12  funct concatenated with opcode; opcode = [6:0], funct3 = [9:7].
REQ-007 SHALL have port addr  input  XLEN  effective byte address (ALU result).
REQ-008 SHALL have port storeData  input  XLEN  rs2 value for stores.
REQ-009 SHALL have port memData  output  32  load word, addressed byte left-justified in [31:24], halfword in [31:16]; registered.
REQ-010 SHALL have port stall  output  1  freeze pipeline; combinational.
REQ-011 SHALL have port done  output  1  one-cycle pulse when an access completes.
REQ-012 SHALL have port misalign  output  1  one-cycle pulse for a misaligned access.
REQ-013 SHALL have port bus_err  output  1  one-cycle pulse on timeout.
REQ-014 SHALL have ports bus_req  output  1, bus_we  output  1, bus_addr  output  32  word-aligned ([1:0]=0), bus_wdata  output  32, bus_wstrb  output  4.
REQ-015 SHALL have ports bus_rdata  input  32 and bus_ack  input  1; bus byte k = bus_rdata/bus_wdata[8k+7:8k] (little-endian lanes).

Function
REQ-016 SHALL implement states IDLE, REQ, DONE.
REQ-017 Memory op = opcode 0000011 (load) or 0100011 (store); other opcodes with valid=1 SHALL be ignored, stall=0.
REQ-018 Alignment: byte ops always aligned; halfword requires addr[0]=0; word requires addr[1:0]=0.
REQ-019 IDLE, valid, memory op, aligned: SHALL register bus_addr={addr[31:2],2'b00}, bus_we, bus_wdata, bus_wstrb, funct3, offset=addr[1:0]; next state REQ.
REQ-020 IDLE, valid, memory op, misaligned: SHALL pulse misalign next cycle, set memData=0, no bus_req, remain IDLE.
REQ-021 Store lanes: SB wstrb=1<<offset, wdata={4{storeData[7:0]}}; SH wstrb=4'b0011<<offset, wdata={2{storeData[15:0]}}; SW wstrb=4'hF, wdata=storeData; loads wstrb=0.
REQ-022 REQ: bus_req=1; bus_addr/we/wdata/wstrb SHALL stay stable until bus_ack sampled high.
REQ-023 REQ with bus_ack=1: load SHALL set memData = bus_rdata << 8*(3-offset) for LB/LBU, << 16*(1-offset[1]) for LH/LHU, bus_rdata for LW; store SHALL leave memData unchanged; next state DONE.
REQ-024 REQ: cycle counter SHALL increment each cycle without ack; on reaching TIMEOUT SHALL pulse bus_err, set memData=0 for loads, go to DONE.
REQ-025 DONE: done=1 for exactly one cycle, bus_req=0, then IDLE; a new access is accepted only from IDLE.
REQ-026 stall SHALL be 1 in REQ, and in IDLE when valid, memory op and aligned; 0 in DONE and otherwise.
REQ-027 bus_ack outside REQ SHALL be ignored.
REQ-028 Latency: with ack in first REQ cycle, done asserts 2 cycles after acceptance.
REQ-029 Funct3 values 3, 6, 7 (reserved) with memory opcode SHALL be treated as word-sized.

Reset
REQ-030 On reset high, asynchronously: state IDLE, bus_req=0, bus_we=0, bus_wstrb=0, bus_addr=0, bus_wdata=0, memData=0, done=0, misalign=0, bus_err=0, counter=0.
REQ-031 Reset mid-REQ SHALL drop bus_req immediately; no done pulse is produced for the aborted access.

Verification
REQ-032 LB addr=0x1002, bus_rdata=0xAABBCCDD, ack in first REQ cycle -> memData=0xBB000000, done on cycle 3, stall high cycles 1-2.
REQ-033 SH addr=0x2002, storeData=0x12345678 -> bus_addr=0x2000, wstrb=4'b1100, wdata=0x56785678, bus_we=1 until ack.
REQ-034 LW addr=0x3001 -> misalign pulse, bus_req never asserted, memData=0, stall=0.
REQ-035 LW with bus_ack held low, TIMEOUT=4 -> bus_err after 4 REQ cycles, memData=0, done pulse, back to IDLE.
REQ-036 Reset asserted in 2nd REQ cycle of SW -> bus_req=0 same cycle, no done; next LW addr=0x10 completes normally.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit: turns one pipeline memory instruction into a single word-wide
// bus transaction with byte lanes, alignment checking and an ack timeout.
module load_store_unit #(
   parameter int XLEN    = 32,
   parameter int TIMEOUT = 255
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            valid,
   input  logic [11:0]     operation,
   input  logic [XLEN-1:0] addr,
   input  logic [XLEN-1:0] storeData,
   output logic [31:0]     memData,
   output logic            stall,
   output logic            done,
   output logic            misalign,
   output logic            bus_err,
   output logic            bus_req,
   output logic            bus_we,
   output logic [31:0]     bus_addr,
   output logic [31:0]     bus_wdata,
   output logic [3:0]      bus_wstrb,
   input  logic [31:0]     bus_rdata,
   input  logic            bus_ack
);

   typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2} state_t;

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   state_t      r_state;
   state_t      w_next;
   logic [2:0]  r_funct3;
   logic [1:0]  r_offset;
   logic [7:0]  r_cnt;
   logic [2:0]  w_funct3;
   logic        w_mem_op;
   logic        w_aligned;
   logic        w_accept;
   logic        w_misal;
   logic        w_timeout;
   logic [3:0]  w_wstrb;
   logic [31:0] w_wdata;
   logic [31:0] w_load_data;
   logic        w_unused;

   assign w_funct3  = operation[9:7];
   assign w_mem_op  = (operation[6:0] == OP_LOAD) || (operation[6:0] == OP_STORE);
   assign w_accept  = (r_state == IDLE) && valid && w_mem_op && w_aligned;
   assign w_misal   = (r_state == IDLE) && valid && w_mem_op && !w_aligned;
   assign w_timeout = (r_state == REQ) && !bus_ack && (r_cnt == CNT_LAST);
   assign w_unused  = ^operation[11:10];

   // Access size decode: funct3[1:0] 00 byte, 01 half, anything else (incl. reserved) word
   always_comb begin
      w_aligned = 1'b1;
      w_wstrb   = 4'hF;
      w_wdata   = storeData[31:0];
      case (w_funct3[1:0])
         2'b00: begin
            w_aligned = 1'b1;
            w_wstrb   = 4'b0001 << addr[1:0];
            w_wdata   = {4{storeData[7:0]}};
         end
         2'b01: begin
            w_aligned = !addr[0];
            w_wstrb   = 4'b0011 << addr[1:0];
            w_wdata   = {2{storeData[15:0]}};
         end
         default: begin
            w_aligned = (addr[1:0] == 2'b00);
            w_wstrb   = 4'hF;
            w_wdata   = storeData[31:0];
         end
      endcase
      if (operation[6:0] != OP_STORE) begin
         w_wstrb = 4'h0;
      end else begin
         w_wstrb = w_wstrb;
      end
   end

   // Left-justify the addressed byte/halfword; lower bits are cleared
   always_comb begin
      case (r_funct3[1:0])
         2'b00:   w_load_data = (bus_rdata << {~r_offset, 3'b000}) & 32'hFF00_0000;
         2'b01:   w_load_data = (bus_rdata << {~r_offset[1], 4'b0000}) & 32'hFFFF_0000;
         default: w_load_data = bus_rdata;
      endcase
   end

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_next;
   end

   // Next-state logic
   always_comb begin
      case (r_state)
         IDLE:    w_next = w_accept ? REQ : IDLE;
         REQ:     w_next = (bus_ack || w_timeout) ? DONE : REQ;
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // State-decoded outputs
   always_comb begin
      bus_req = (r_state == REQ);
      done    = (r_state == DONE);
      stall   = (r_state == REQ) || w_accept;
   end

   // Bus request fields are captured at acceptance and held until the access ends
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bus_addr  <= 32'h0;
         bus_we    <= 1'b0;
         bus_wdata <= 32'h0;
         bus_wstrb <= 4'h0;
         r_funct3  <= 3'd0;
         r_offset  <= 2'd0;
         r_cnt     <= 8'd0;
         misalign  <= 1'b0;
         bus_err   <= 1'b0;
      end else begin
         misalign <= w_misal;
         bus_err  <= w_timeout;
         if (w_accept) begin
            bus_addr  <= {addr[31:2], 2'b00};
            bus_we    <= (operation[6:0] == OP_STORE);
            bus_wdata <= w_wdata;
            bus_wstrb <= w_wstrb;
            r_funct3  <= w_funct3;
            r_offset  <= addr[1:0];
            r_cnt     <= 8'd0;
         end else if (r_state == REQ) begin
            if (bus_ack || w_timeout) begin
               bus_we    <= 1'b0;
               bus_wstrb <= 4'h0;
            end else begin
               r_cnt <= r_cnt + 8'd1;
            end
         end else begin
            r_cnt <= r_cnt;
         end
      end
   end

   // Load result register; stores leave it untouched
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         memData <= 32'h0;
      end else if (w_misal) begin
         memData <= 32'h0;
      end else if ((r_state == REQ) && bus_ack && !bus_we) begin
         memData <= w_load_data;
      end else if (w_timeout && !bus_we) begin
         memData <= 32'h0;
      end else begin
         memData <= memData;
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus random accesses
// compared against a byte-lane level reference model.
module tb_load_store_unit;
   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        valid;
   logic [11:0] operation;
   logic [31:0] addr, storeData, memData, bus_addr, bus_wdata, bus_rdata;
   logic        stall, done, misalign, bus_err, bus_req, bus_we, bus_ack;
   logic [3:0]  bus_wstrb;

   int total = 0;
   int bad   = 0;
   logic [31:0] exp_mem = 32'h0;

   load_store_unit #(.XLEN(32), .TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset), .valid(valid), .operation(operation), .addr(addr),
      .storeData(storeData), .memData(memData), .stall(stall), .done(done),
      .misalign(misalign), .bus_err(bus_err), .bus_req(bus_req), .bus_we(bus_we),
      .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
      .bus_rdata(bus_rdata), .bus_ack(bus_ack)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // kind: 0 load, 1 store, 2 non-memory. dly = REQ cycles without ack before ack.
   task automatic access(input int kind, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] sd, input logic [31:0] rd, input int dly,
                         input logic noise);
      int size, off;
      logic mem, aligned, to;
      logic [6:0]  opc;
      logic [3:0]  e_strb;
      logic [31:0] e_wdata, lane;
      size    = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
      off     = int'(a % 4);
      mem     = (kind != 2);
      aligned = ((a % size) == 0);
      opc     = (kind == 0) ? 7'b0000011 : (kind == 1) ? 7'b0100011 : 7'b0110011;
      valid     = 1'b1;
      operation = {2'($urandom_range(0, 3)), f3, opc};
      addr      = a;
      storeData = sd;
      bus_ack   = noise;
      bus_rdata = $urandom;
      #1;
      chk("stall_accept", 32'(stall), 32'(mem && aligned));
      tick();
      valid   = 1'b0;
      bus_ack = 1'b0;
      if (!mem) begin
         chk("nonmem_req", 32'(bus_req), 32'h0);
         chk("nonmem_misal", 32'(misalign), 32'h0);
         return;
      end
      if (!aligned) begin
         exp_mem = 32'h0;
         chk("misal_pulse", 32'(misalign), 32'h1);
         chk("misal_noreq", 32'(bus_req), 32'h0);
         chk("misal_mem", memData, exp_mem);
         tick();
         chk("misal_end", 32'(misalign), 32'h0);
         return;
      end
      e_strb  = (kind == 1) ? 4'(((1 << size) - 1) << off) : 4'h0;
      e_wdata = (size == 1) ? sd[7:0] * 32'h0101_0101 :
                (size == 2) ? sd[15:0] * 32'h0001_0001 : sd;
      for (int c = 0; c < TO; c++) begin
         chk("req_busreq", 32'(bus_req), 32'h1);
         chk("req_stall", 32'(stall), 32'h1);
         chk("req_addr", bus_addr, a & 32'hFFFF_FFFC);
         chk("req_we", 32'(bus_we), 32'(kind == 1));
         chk("req_wstrb", 32'(bus_wstrb), 32'(e_strb));
         if (kind == 1) chk("req_wdata", bus_wdata, e_wdata);
         bus_ack   = (c == dly);
         bus_rdata = (c == dly) ? rd : $urandom;
         tick();
         bus_ack = 1'b0;
         if (c == dly) break;
      end
      to = (dly >= TO);
      if (kind == 0) begin
         if (to) begin
            exp_mem = 32'h0;
         end else if (size == 1) begin
            lane    = (rd >> (8 * off)) & 32'hFF;
            exp_mem = lane << 24;
         end else if (size == 2) begin
            lane    = (rd >> (8 * off)) & 32'hFFFF;
            exp_mem = lane << 16;
         end else begin
            exp_mem = rd;
         end
      end
      chk("done_pulse", 32'(done), 32'h1);
      chk("done_busreq", 32'(bus_req), 32'h0);
      chk("done_stall", 32'(stall), 32'h0);
      chk("done_buserr", 32'(bus_err), 32'(to));
      chk("done_mem", memData, exp_mem);
      tick();
      chk("idle_done", 32'(done), 32'h0);
      chk("idle_buserr", 32'(bus_err), 32'h0);
      chk("idle_mem", memData, exp_mem);
   endtask

   initial begin
      reset = 1'b1; valid = 1'b0; operation = 12'h0; addr = 32'h0; storeData = 32'h0;
      bus_rdata = 32'h0; bus_ack = 1'b0;
      #12;
      chk("rst_req", 32'(bus_req), 32'h0);
      chk("rst_we", 32'(bus_we), 32'h0);
      chk("rst_strb", 32'(bus_wstrb), 32'h0);
      chk("rst_addr", bus_addr, 32'h0);
      chk("rst_wdata", bus_wdata, 32'h0);
      chk("rst_mem", memData, 32'h0);
      chk("rst_flags", {29'h0, done, misalign, bus_err}, 32'h0);
      tick();
      reset = 1'b0;
      tick();

      // LB byte 2 of 0xAABBCCDD, ack in the first REQ cycle
      access(0, 3'd0, 32'h1002, 32'h0, 32'hAABB_CCDD, 0, 1'b0);
      chk("lb_result", memData, 32'hBB00_0000);
      // SH upper half
      access(1, 3'd1, 32'h2002, 32'h1234_5678, 32'h0, 1, 1'b0);
      // LW misaligned
      access(0, 3'd2, 32'h3001, 32'h0, 32'h0, 0, 1'b0);
      // LW timeout
      access(0, 3'd2, 32'h4000, 32'h0, 32'hDEAD_BEEF, TO + 2, 1'b0);
      // LHU upper half, reserved funct3 treated as word, ack in last REQ cycle
      access(0, 3'd5, 32'h5002, 32'h0, 32'hCAFE_F00D, 2, 1'b1);
      access(0, 3'd7, 32'h6004, 32'h0, 32'h0BAD_F00D, TO - 1, 1'b0);
      access(1, 3'd6, 32'h6006, 32'h0, 32'h0, 0, 1'b0);

      // Reset in the 2nd REQ cycle of a SW
      valid = 1'b1; operation = {2'b00, 3'd2, 7'b0100011}; addr = 32'h40; storeData = 32'h1111_2222;
      tick();
      valid = 1'b0;
      tick();
      chk("abort_req_before", 32'(bus_req), 32'h1);
      reset = 1'b1;
      #1;
      chk("abort_req_drop", 32'(bus_req), 32'h0);
      chk("abort_stall", 32'(stall), 32'h0);
      tick();
      reset = 1'b0;
      chk("abort_nodone0", 32'(done), 32'h0);
      tick();
      chk("abort_nodone1", 32'(done), 32'h0);
      exp_mem = 32'h0;
      access(0, 3'd2, 32'h10, 32'h0, 32'h7654_3210, 0, 1'b0);

      for (int n = 0; n < 60; n++) begin
         int k;
         k = $urandom_range(0, 9);
         access((k < 4) ? 0 : (k < 8) ? 1 : 2, 3'($urandom_range(0, 7)), $urandom, $urandom,
                $urandom, $urandom_range(0, TO + 1), 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 3) == 0) tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
